// File: rtl/mips_decode_stage.sv
// mips_decode_stage: registered MIPS-I decode stage between fetch and execute.
// Each accepted instruction is classified to a numeric op id on the way in and
// written into a DEPTH-entry buffer. The register fields and the extended
// immediate are derived from the entry at the buffer head.
//
// Handshake (both sides): a transfer happens on a rising edge when valid and
// ready are both high in the cycle before it. in_ready depends only on
// registered state. out_valid stays high, and the head entry stays unchanged,
// until the consumer takes it. A flush in the same cycle blocks the input
// transfer.
module mips_decode_stage #(
    parameter int DEPTH = 2,
    parameter int IMM_W = 32,
    parameter int PC_W  = 32,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [31:0]      in_instr,
    input  logic [PC_W-1:0]  in_pc,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [5:0]       out_op,
    output logic [4:0]       out_rs,
    output logic [4:0]       out_rt,
    output logic [4:0]       out_rd,
    output logic [4:0]       out_shamt,
    output logic [IMM_W-1:0] out_imm,
    output logic [25:0]      out_target,
    output logic [PC_W-1:0]  out_pc,
    output logic             out_illegal,
    output logic [CNT_W-1:0] cnt_decoded,
    output logic [CNT_W-1:0] cnt_illegal
);
    localparam int PTR_W  = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_BW = $clog2(DEPTH + 1);

    localparam logic [5:0] OP_ILL  = 6'd0;
    localparam logic [5:0] OP_ANDI = 6'd40;
    localparam logic [5:0] OP_ORI  = 6'd41;
    localparam logic [5:0] OP_XORI = 6'd42;
    localparam logic [5:0] OP_LUI  = 6'd43;

    logic [5:0]        w_opc;
    logic [5:0]        w_funct;
    logic [4:0]        w_rt_in;
    logic [5:0]        w_dec_op;
    logic              w_accept;
    logic              w_pop;
    logic              w_nonempty;
    logic [PTR_W-1:0]  r_wr_ptr;
    logic [PTR_W-1:0]  r_rd_ptr;
    logic [CNT_BW-1:0] r_count;
    logic [CNT_BW-1:0] w_count_nxt;
    logic              r_in_ready;

    // Buffer entries keep the op id, the low 26 instruction bits and the pc.
    logic [5:0]        r_mem_op  [DEPTH];
    logic [25:0]       r_mem_fld [DEPTH];
    logic [PC_W-1:0]   r_mem_pc  [DEPTH];

    // Copy of the most recent head entry, shown while the buffer is empty.
    logic [5:0]        r_hold_op;
    logic [25:0]       r_hold_fld;
    logic [PC_W-1:0]   r_hold_pc;

    logic [5:0]        w_cur_op;
    logic [25:0]       w_cur_fld;
    logic [PC_W-1:0]   w_cur_pc;
    logic signed [15:0] w_imm16_s;
    logic signed [31:0] w_lui_s;
    logic [IMM_W-1:0]  w_imm;
    logic [CNT_W-1:0]  r_cnt_dec;
    logic [CNT_W-1:0]  r_cnt_ill;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        if (p == PTR_W'(DEPTH - 1)) return '0;
        return p + PTR_W'(1);
    endfunction

    assign w_opc      = in_instr[31:26];
    assign w_funct    = in_instr[5:0];
    assign w_rt_in    = in_instr[20:16];
    assign w_nonempty = (r_count != '0);
    assign w_accept   = in_valid & r_in_ready & ~flush;
    assign w_pop      = w_nonempty & out_ready;

    // Classify the incoming word to its op id; unknown encodings become ILL.
    always_comb begin
        w_dec_op = OP_ILL;
        if (in_instr == 32'h0) begin
            w_dec_op = 6'd1;                                 // NOP
        end else begin
            case (w_opc)
                6'h00: begin
                    case (w_funct)
                        6'h00: w_dec_op = 6'd2;              // SLL
                        6'h02: w_dec_op = 6'd3;              // SRL
                        6'h03: w_dec_op = 6'd4;              // SRA
                        6'h04: w_dec_op = 6'd5;              // SLLV
                        6'h06: w_dec_op = 6'd6;              // SRLV
                        6'h07: w_dec_op = 6'd7;              // SRAV
                        6'h08: w_dec_op = 6'd8;              // JR
                        6'h09: w_dec_op = 6'd9;              // JALR
                        6'h10: w_dec_op = 6'd10;             // MFHI
                        6'h12: w_dec_op = 6'd11;             // MFLO
                        6'h18: w_dec_op = 6'd12;             // MULT
                        6'h19: w_dec_op = 6'd13;             // MULTU
                        6'h1A: w_dec_op = 6'd14;             // DIV
                        6'h1B: w_dec_op = 6'd15;             // DIVU
                        6'h20: w_dec_op = 6'd16;             // ADD
                        6'h21: w_dec_op = 6'd17;             // ADDU
                        6'h22: w_dec_op = 6'd18;             // SUB
                        6'h23: w_dec_op = 6'd19;             // SUBU
                        6'h24: w_dec_op = 6'd20;             // AND
                        6'h25: w_dec_op = 6'd21;             // OR
                        6'h26: w_dec_op = 6'd22;             // XOR
                        6'h27: w_dec_op = 6'd23;             // NOR
                        6'h2A: w_dec_op = 6'd24;             // SLT
                        6'h2B: w_dec_op = 6'd25;             // SLTU
                        default: w_dec_op = OP_ILL;
                    endcase
                end
                6'h01: begin
                    if (w_rt_in == 5'd1)      w_dec_op = 6'd26;   // BGEZ
                    else if (w_rt_in == 5'd0) w_dec_op = 6'd27;   // BLTZ
                end
                6'h02: w_dec_op = 6'd28;                                  // J
                6'h03: w_dec_op = 6'd29;                                  // JAL
                6'h04: w_dec_op = (w_rt_in == 5'd0) ? 6'd31 : 6'd30;     // BEQZ/BEQ
                6'h05: w_dec_op = (w_rt_in == 5'd0) ? 6'd33 : 6'd32;     // BNEZ/BNE
                6'h06: w_dec_op = 6'd34;                                  // BLEZ
                6'h07: w_dec_op = 6'd35;                                  // BGTZ
                6'h08: w_dec_op = 6'd36;                                  // ADDI
                6'h09: w_dec_op = 6'd37;                                  // ADDIU
                6'h0A: w_dec_op = 6'd38;                                  // SLTI
                6'h0B: w_dec_op = 6'd39;                                  // SLTIU
                6'h0C: w_dec_op = OP_ANDI;
                6'h0D: w_dec_op = OP_ORI;
                6'h0E: w_dec_op = OP_XORI;
                6'h0F: w_dec_op = OP_LUI;
                6'h20: w_dec_op = 6'd44;                                  // LB
                6'h23: w_dec_op = 6'd45;                                  // LW
                6'h24: w_dec_op = 6'd46;                                  // LBU
                6'h28: w_dec_op = 6'd47;                                  // SB
                6'h2B: w_dec_op = 6'd48;                                  // SW
                default: w_dec_op = OP_ILL;
            endcase
        end
    end

    // Occupancy after this edge: accept and pop together leave it unchanged.
    always_comb begin
        w_count_nxt = r_count;
        if (w_accept && !w_pop)      w_count_nxt = r_count + CNT_BW'(1);
        else if (!w_accept && w_pop) w_count_nxt = r_count - CNT_BW'(1);
    end

    // Pointer, occupancy and ready registers; flush empties the buffer.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_count    <= '0;
            r_in_ready <= 1'b1;
        end else if (flush) begin
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_count    <= '0;
            r_in_ready <= 1'b1;
        end else begin
            if (w_accept) r_wr_ptr <= ptr_inc(r_wr_ptr);
            if (w_pop)    r_rd_ptr <= ptr_inc(r_rd_ptr);
            r_count    <= w_count_nxt;
            r_in_ready <= (w_count_nxt < CNT_BW'(DEPTH));
        end
    end

    // Write the decoded instruction into the tail entry.
    always_ff @(posedge clk) begin
        if (w_accept) begin
            r_mem_op[r_wr_ptr]  <= w_dec_op;
            r_mem_fld[r_wr_ptr] <= in_instr[25:0];
            r_mem_pc[r_wr_ptr]  <= in_pc;
        end
    end

    // Track the head entry so the outputs keep their last value once empty.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_hold_op  <= '0;
            r_hold_fld <= '0;
            r_hold_pc  <= '0;
        end else if (w_nonempty) begin
            r_hold_op  <= r_mem_op[r_rd_ptr];
            r_hold_fld <= r_mem_fld[r_rd_ptr];
            r_hold_pc  <= r_mem_pc[r_rd_ptr];
        end
    end

    // Saturating counters of accepted and of accepted illegal instructions.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt_dec <= '0;
            r_cnt_ill <= '0;
        end else if (w_accept) begin
            if (r_cnt_dec != '1) r_cnt_dec <= r_cnt_dec + CNT_W'(1);
            if ((w_dec_op == OP_ILL) && (r_cnt_ill != '1)) r_cnt_ill <= r_cnt_ill + CNT_W'(1);
        end
    end

    assign w_cur_op  = w_nonempty ? r_mem_op[r_rd_ptr]  : r_hold_op;
    assign w_cur_fld = w_nonempty ? r_mem_fld[r_rd_ptr] : r_hold_fld;
    assign w_cur_pc  = w_nonempty ? r_mem_pc[r_rd_ptr]  : r_hold_pc;
    assign w_imm16_s = w_cur_fld[15:0];
    assign w_lui_s   = {w_cur_fld[15:0], 16'h0};

    // Logical immediates zero-extend, LUI places the half-word on top, the rest sign-extend.
    always_comb begin
        w_imm = IMM_W'(w_imm16_s);
        if ((w_cur_op == OP_ANDI) || (w_cur_op == OP_ORI) || (w_cur_op == OP_XORI))
            w_imm = IMM_W'(w_cur_fld[15:0]);
        else if (w_cur_op == OP_LUI)
            w_imm = IMM_W'(w_lui_s);
    end

    assign in_ready    = r_in_ready;
    assign out_valid   = w_nonempty;
    assign out_op      = w_cur_op;
    assign out_rs      = w_cur_fld[25:21];
    assign out_rt      = w_cur_fld[20:16];
    assign out_rd      = w_cur_fld[15:11];
    assign out_shamt   = w_cur_fld[10:6];
    assign out_imm     = w_imm;
    assign out_target  = w_cur_fld;
    assign out_pc      = w_cur_pc;
    assign out_illegal = w_nonempty & (w_cur_op == OP_ILL);
    assign cnt_decoded = r_cnt_dec;
    assign cnt_illegal = r_cnt_ill;

endmodule

// File: tb/tb_mips_decode_stage.sv
// Testbench for mips_decode_stage: directed scenarios plus random traffic
// checked against a table-driven decode model and an expected-entry queue.
module tb_mips_decode_stage;
    localparam int DEPTH   = 2;
    localparam int IMM_W   = 32;
    localparam int PC_W    = 32;
    localparam int CNT_W   = 4;
    localparam int CNT_MAX = 15;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic             flush = 1'b0;
    logic             in_valid = 1'b0;
    logic             out_ready = 1'b0;
    logic [31:0]      in_instr = '0;
    logic [PC_W-1:0]  in_pc = '0;
    logic             in_ready;
    logic             out_valid;
    logic [5:0]       out_op;
    logic [4:0]       out_rs, out_rt, out_rd, out_shamt;
    logic [IMM_W-1:0] out_imm;
    logic [25:0]      out_target;
    logic [PC_W-1:0]  out_pc;
    logic             out_illegal;
    logic [CNT_W-1:0] cnt_decoded, cnt_illegal;
    logic [116:0]     act_fields;

    int n_checks = 0;
    int n_fail   = 0;
    logic [63:0] exp_q[$];          // {pc, instr} of entries the DUT should hold, oldest first
    int m_dec = 0;
    int m_ill = 0;
    int spec_tbl[64];
    int prim_tbl[64];

    mips_decode_stage #(.DEPTH(DEPTH), .IMM_W(IMM_W), .PC_W(PC_W), .CNT_W(CNT_W)) dut (
        .clk(clk), .rst_n(rst_n), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready), .in_instr(in_instr), .in_pc(in_pc),
        .out_valid(out_valid), .out_ready(out_ready), .out_op(out_op),
        .out_rs(out_rs), .out_rt(out_rt), .out_rd(out_rd), .out_shamt(out_shamt),
        .out_imm(out_imm), .out_target(out_target), .out_pc(out_pc), .out_illegal(out_illegal),
        .cnt_decoded(cnt_decoded), .cnt_illegal(cnt_illegal)
    );

    assign act_fields = {out_op, out_rs, out_rt, out_rd, out_shamt, out_imm, out_target, out_pc, out_illegal};

    // ---------------- clock ----------------
    always #5 clk = ~clk;

    // ---------------- reference model ----------------
    task automatic init_tables();
        for (int k = 0; k < 64; k++) begin
            spec_tbl[k] = 0;
            prim_tbl[k] = 0;
        end
        spec_tbl[0] = 2;  spec_tbl[2] = 3;  spec_tbl[3] = 4;  spec_tbl[4] = 5;
        spec_tbl[6] = 6;  spec_tbl[7] = 7;  spec_tbl[8] = 8;  spec_tbl[9] = 9;
        spec_tbl[16] = 10; spec_tbl[18] = 11; spec_tbl[24] = 12; spec_tbl[25] = 13;
        spec_tbl[26] = 14; spec_tbl[27] = 15;
        for (int k = 0; k < 8; k++) spec_tbl[32 + k] = 16 + k;
        spec_tbl[42] = 24; spec_tbl[43] = 25;
        prim_tbl[2] = 28; prim_tbl[3] = 29; prim_tbl[6] = 34; prim_tbl[7] = 35;
        for (int k = 0; k < 8; k++) prim_tbl[8 + k] = 36 + k;
        prim_tbl[32] = 44; prim_tbl[35] = 45; prim_tbl[36] = 46; prim_tbl[40] = 47; prim_tbl[43] = 48;
    endtask

    function automatic int model_op(input logic [31:0] w);
        logic [5:0] opc;
        logic [4:0] rt;
        opc = w[31:26];
        rt  = w[20:16];
        if (w == 32'h0) return 1;
        if (opc == 6'h00) return spec_tbl[w[5:0]];
        if (opc == 6'h01) return (rt == 5'd1) ? 26 : ((rt == 5'd0) ? 27 : 0);
        if (opc == 6'h04) return (rt == 5'd0) ? 31 : 30;
        if (opc == 6'h05) return (rt == 5'd0) ? 33 : 32;
        return prim_tbl[opc];
    endfunction

    function automatic logic [31:0] model_imm(input logic [31:0] w, input int op);
        logic [15:0] lo;
        lo = w[15:0];
        if (op >= 40 && op <= 42) return {16'h0, lo};
        if (op == 43) return {lo, 16'h0};
        return {{16{lo[15]}}, lo};
    endfunction

    function automatic logic [116:0] exp_fields(input logic [63:0] e);
        logic [31:0] w;
        int op;
        w  = e[31:0];
        op = model_op(w);
        return {6'(op), w[25:21], w[20:16], w[15:11], w[10:6], model_imm(w, op), w[25:0], e[63:32], (op == 0)};
    endfunction

    function automatic logic [31:0] gen_instr();
        logic [31:0] w;
        logic [5:0]  prim[20];
        prim = '{6'h01, 6'h02, 6'h03, 6'h04, 6'h05, 6'h06, 6'h07, 6'h08, 6'h09, 6'h0A,
                 6'h0B, 6'h0C, 6'h0D, 6'h0E, 6'h0F, 6'h20, 6'h23, 6'h24, 6'h28, 6'h2B};
        w = $urandom;
        case ($urandom_range(0, 4))
            0: ;
            1: begin
                w[31:26] = 6'h00;
                if ($urandom_range(0, 3) == 0) w[5:0] = 6'h00;
            end
            2: w[31:26] = prim[$urandom_range(0, 19)];
            3: begin
                w[31:26] = 6'h01;
                w[20:16] = 5'($urandom_range(0, 3));
            end
            default: begin
                if ($urandom_range(0, 1) == 0) begin
                    w = 32'h0;
                end else begin
                    w[31:26] = 6'h04 + 6'($urandom_range(0, 1));
                    w[20:16] = 5'd0;
                end
            end
        endcase
        return w;
    endfunction

    // ---------------- scoreboard ----------------
    // Sampled at the falling edge: state reflects the last rising edge, inputs
    // show what the next rising edge will see.
    always @(negedge clk) begin
        logic can_acc;
        if (!rst_n) begin
            exp_q.delete();
            m_dec = 0;
            m_ill = 0;
        end else begin
            n_checks++;
            if (out_valid !== (exp_q.size() != 0)) begin
                n_fail++;
                $display("FAIL sb_out_valid: got %b want %0d", out_valid, exp_q.size() != 0);
            end
            n_checks++;
            if (in_ready !== (exp_q.size() < DEPTH)) begin
                n_fail++;
                $display("FAIL sb_in_ready: got %b want %0d", in_ready, exp_q.size() < DEPTH);
            end
            n_checks++;
            if ({cnt_decoded, cnt_illegal} !== {CNT_W'(m_dec), CNT_W'(m_ill)}) begin
                n_fail++;
                $display("FAIL sb_counters: got %0d/%0d want %0d/%0d", cnt_decoded, cnt_illegal, m_dec, m_ill);
            end
            if (exp_q.size() != 0) begin
                n_checks++;
                if (act_fields !== exp_fields(exp_q[0])) begin
                    n_fail++;
                    $display("FAIL sb_head: got %h want %h (instr %h)", act_fields, exp_fields(exp_q[0]), exp_q[0][31:0]);
                end
            end
            can_acc = in_valid && (exp_q.size() < DEPTH);
            if (flush) begin
                exp_q.delete();
            end else begin
                if ((exp_q.size() != 0) && out_ready) void'(exp_q.pop_front());
                if (can_acc) begin
                    exp_q.push_back({in_pc, in_instr});
                    if (m_dec < CNT_MAX) m_dec++;
                    if (model_op(in_instr) == 0 && m_ill < CNT_MAX) m_ill++;
                end
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic do_reset();
        @(posedge clk); #1;
        rst_n = 1'b0; in_valid = 1'b0; flush = 1'b0; out_ready = 1'b0; in_instr = '0; in_pc = '0;
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
    endtask

    task automatic test_reset();
        do_reset();
        @(negedge clk);
        n_checks++;
        if ({out_valid, in_ready, out_illegal} !== 3'b010) begin
            n_fail++; $display("FAIL reset_flags: got v/r/ill %b%b%b want 010", out_valid, in_ready, out_illegal);
        end
        n_checks++;
        if ({out_op, out_imm, out_pc, out_target} !== '0) begin
            n_fail++; $display("FAIL reset_outputs: got op %0d imm %h pc %h want zeros", out_op, out_imm, out_pc);
        end
        n_checks++;
        if ({cnt_decoded, cnt_illegal} !== '0) begin
            n_fail++; $display("FAIL reset_counters: got %0d/%0d want 0/0", cnt_decoded, cnt_illegal);
        end
    endtask

    task automatic test_stream();
        logic [31:0] ins[4];
        int          ops[4];
        logic [31:0] imms[4];
        int          rts[4];
        ins  = '{32'h00000000, 32'h2008FFFF, 32'h3C011234, 32'h3421FFFF};
        ops  = '{1, 36, 43, 41};
        imms = '{32'h0, 32'hFFFFFFFF, 32'h12340000, 32'h0000FFFF};
        rts  = '{0, 8, 1, 1};
        @(posedge clk); #1;
        out_ready = 1'b1; in_valid = 1'b1; in_instr = ins[0]; in_pc = 32'h1000;
        for (int i = 0; i < 4; i++) begin
            @(posedge clk); #1;
            if (i < 3) begin
                in_instr = ins[i + 1]; in_pc = 32'h1000 + 32'(4 * (i + 1));
            end else begin
                in_valid = 1'b0;
            end
            @(negedge clk);
            n_checks++;
            if (out_valid !== 1'b1 || out_op !== 6'(ops[i]) || out_imm !== imms[i] || out_rt !== 5'(rts[i])) begin
                n_fail++;
                $display("FAIL stream_%0d: got v %b op %0d imm %h rt %0d want v 1 op %0d imm %h rt %0d",
                         i, out_valid, out_op, out_imm, out_rt, ops[i], imms[i], rts[i]);
            end
        end
    endtask

    task automatic test_branch();
        logic [31:0] ins[3];
        int          ops[3];
        int          rss[3];
        logic [31:0] imms[3];
        ins  = '{32'h10A00004, 32'h04210003, 32'h04420003};
        ops  = '{31, 26, 0};
        rss  = '{5, 1, 2};
        imms = '{32'd4, 32'd3, 32'd3};
        do_reset();
        out_ready = 1'b1; in_valid = 1'b1; in_instr = ins[0];
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            if (i < 2) in_instr = ins[i + 1];
            else in_valid = 1'b0;
            @(negedge clk);
            n_checks++;
            if (out_op !== 6'(ops[i]) || out_rs !== 5'(rss[i]) || out_imm !== imms[i] || out_illegal !== (ops[i] == 0)) begin
                n_fail++;
                $display("FAIL branch_%0d: got op %0d rs %0d imm %h ill %b want op %0d rs %0d imm %h",
                         i, out_op, out_rs, out_imm, out_illegal, ops[i], rss[i], imms[i]);
            end
        end
        repeat (2) @(posedge clk);
        @(negedge clk);
        n_checks++;
        if (cnt_decoded !== CNT_W'(3) || cnt_illegal !== CNT_W'(1)) begin
            n_fail++; $display("FAIL branch_counters: got %0d/%0d want 3/1", cnt_decoded, cnt_illegal);
        end
    endtask

    task automatic test_backpressure();
        logic [31:0]     bp[4];
        logic [PC_W-1:0] got_pc[4];
        logic [116:0]    snap;
        logic            have_snap;
        logic            acc;
        int              sent;
        int              got;
        int              cyc;
        bp = '{32'h00851020, 32'h8C220010, 32'hAC220010, 32'h30A5F0F0};
        sent = 0; got = 0; cyc = 0; have_snap = 1'b0; snap = '0;
        for (int k = 0; k < 4; k++) got_pc[k] = '0;
        @(posedge clk); #1;
        out_ready = 1'b0;
        for (int c = 0; c < 8; c++) begin
            in_valid = (sent < 4); in_instr = bp[sent % 4]; in_pc = 32'h100 + 32'(4 * sent);
            @(negedge clk);
            if (have_snap) begin
                n_checks++;
                if (act_fields !== snap) begin
                    n_fail++; $display("FAIL bp_head_stable: got %h want %h", act_fields, snap);
                end
            end else if (out_valid) begin
                snap = act_fields; have_snap = 1'b1;
            end
            acc = in_valid && in_ready;
            @(posedge clk); #1;
            if (acc) sent++;
        end
        @(negedge clk);
        n_checks++;
        if (sent != DEPTH || in_ready !== 1'b0) begin
            n_fail++; $display("FAIL bp_accept_depth: got %0d accepted ready %b want %0d ready 0", sent, in_ready, DEPTH);
        end
        @(posedge clk); #1;
        out_ready = 1'b1;
        while (got < 4 && cyc < 40) begin
            in_valid = (sent < 4); in_instr = bp[sent % 4]; in_pc = 32'h100 + 32'(4 * sent);
            @(negedge clk);
            acc = in_valid && in_ready;
            if (out_valid) begin
                got_pc[got] = out_pc;
                got++;
            end
            @(posedge clk); #1;
            if (acc) sent++;
            cyc++;
        end
        in_valid = 1'b0;
        n_checks++;
        if (got != 4) begin
            n_fail++; $display("FAIL bp_drain_count: got %0d outputs in %0d cycles want 4", got, cyc);
        end
        for (int k = 0; k < 4; k++) begin
            n_checks++;
            if (got_pc[k] !== 32'h100 + 32'(4 * k)) begin
                n_fail++; $display("FAIL bp_order_%0d: got pc %h want %h", k, got_pc[k], 32'h100 + 32'(4 * k));
            end
        end
        @(negedge clk);
        n_checks++;
        if (out_valid !== 1'b0) begin
            n_fail++; $display("FAIL bp_no_duplicate: got out_valid %b want 0", out_valid);
        end
    endtask

    task automatic test_flush();
        int   acc_n;
        logic acc;
        acc_n = 0;
        do_reset();
        out_ready = 1'b0;
        for (int c = 0; c < 6 && acc_n < DEPTH; c++) begin
            in_valid = 1'b1; in_instr = 32'h00221820; in_pc = 32'(c);
            @(negedge clk);
            acc = in_ready;
            @(posedge clk); #1;
            if (acc) acc_n++;
        end
        in_valid = 1'b1; flush = 1'b1; in_instr = 32'h3C01ABCD;
        @(posedge clk); #1;
        flush = 1'b0; in_valid = 1'b0;
        @(negedge clk);
        n_checks++;
        if (acc_n != DEPTH || out_valid !== 1'b0 || in_ready !== 1'b1 || cnt_decoded !== CNT_W'(DEPTH)) begin
            n_fail++;
            $display("FAIL flush_full: got filled %0d v %b r %b cnt %0d want %0d 0 1 %0d",
                     acc_n, out_valid, in_ready, cnt_decoded, DEPTH, DEPTH);
        end
        @(posedge clk); #1;
        in_valid = 1'b1; flush = 1'b1;
        @(posedge clk); #1;
        flush = 1'b0; in_valid = 1'b0;
        @(negedge clk);
        n_checks++;
        if (out_valid !== 1'b0 || cnt_decoded !== CNT_W'(DEPTH)) begin
            n_fail++; $display("FAIL flush_blocks_input: got v %b cnt %0d want 0 %0d", out_valid, cnt_decoded, DEPTH);
        end
    endtask

    task automatic test_saturate();
        int   acc_n;
        logic acc;
        acc_n = 0;
        do_reset();
        out_ready = 1'b1;
        for (int c = 0; c < 60 && acc_n < 20; c++) begin
            in_valid = 1'b1; in_instr = 32'hFC000000; in_pc = 32'(c);
            @(negedge clk);
            acc = in_ready;
            @(posedge clk); #1;
            if (acc) acc_n++;
        end
        in_valid = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        n_checks++;
        if (acc_n != 20 || cnt_decoded !== CNT_W'(CNT_MAX) || cnt_illegal !== CNT_W'(CNT_MAX)) begin
            n_fail++;
            $display("FAIL saturate: got sent %0d cnt %0d/%0d want 20 %0d/%0d", acc_n, cnt_decoded, cnt_illegal, CNT_MAX, CNT_MAX);
        end
    endtask

    task automatic test_async_reset();
        @(posedge clk); #1;
        out_ready = 1'b1;
        for (int c = 0; c < 4; c++) begin
            in_valid = 1'b1; in_instr = 32'h21080001 + 32'(c); in_pc = 32'h200 + 32'(4 * c);
            @(posedge clk); #1;
        end
        #1 rst_n = 1'b0;
        #1;
        n_checks++;
        if ({out_valid, out_illegal} !== 2'b00 || {out_op, out_imm, out_pc} !== '0 || {cnt_decoded, cnt_illegal} !== '0) begin
            n_fail++;
            $display("FAIL async_reset: got v %b op %0d imm %h pc %h cnt %0d/%0d want all 0",
                     out_valid, out_op, out_imm, out_pc, cnt_decoded, cnt_illegal);
        end
        in_valid = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        in_valid = 1'b1; in_instr = 32'h2008FFFF; in_pc = 32'h400;
        @(posedge clk); #1;
        in_valid = 1'b0;
        @(negedge clk);
        n_checks++;
        if (out_valid !== 1'b1 || out_op !== 6'd36 || out_imm !== 32'hFFFFFFFF || out_rt !== 5'd8 ||
            out_pc !== 32'h400 || cnt_decoded !== CNT_W'(1)) begin
            n_fail++;
            $display("FAIL post_reset_decode: got v %b op %0d imm %h rt %0d pc %h cnt %0d want 1 36 ffffffff 8 400 1",
                     out_valid, out_op, out_imm, out_rt, out_pc, cnt_decoded);
        end
    endtask

    task automatic test_random();
        do_reset();
        for (int c = 0; c < 400; c++) begin
            in_valid  = ($urandom_range(0, 9) < 7);
            out_ready = ($urandom_range(0, 9) < 6);
            flush     = ($urandom_range(0, 29) == 0);
            in_instr  = gen_instr();
            in_pc     = $urandom;
            @(posedge clk); #1;
        end
        flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
        repeat (4) @(posedge clk);
        @(negedge clk);
        n_checks++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
            n_fail++; $display("FAIL random_drain: got v %b r %b want 0 1", out_valid, in_ready);
        end
    endtask

    // ---------------- sequence and report ----------------
    initial begin
        init_tables();
        test_reset();
        test_stream();
        test_branch();
        test_backpressure();
        test_flush();
        test_saturate();
        test_async_reset();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #100000;
        n_fail++;
        $display("FAIL watchdog: got no completion by 100000 ns want completion");
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
